bin_bcd_secuencial: RTL and testbench

Sequential, parametrised binary-to-BCD converter using iterative double-dabble, one bit per clock. It sits between the keypad accumulator and display logic and offers an optional two's-complement input mode. It has a start/busy/done handshake and a sticky overflow flag for values that exceed the configured digit count. It replaces the purely combinational 12-bit/4-digit converter where timing or area matters.

---
 rtl/bin_bcd_secuencial_if.sv | 16 +
 rtl/bin_bcd_secuencial.sv | 98 +++++++++
 tb/tb_bin_bcd_secuencial.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bin_bcd_secuencial_if.sv
// bin_bcd_secuencial_if: start/busy/done handshake and data bus of the sequential binary-to-BCD converter
interface bin_bcd_secuencial_if #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [WIDTH-1:0]      binario;
    logic                  con_signo;
    logic [4*DIGITS-1:0]   bcd;
    logic                  negativo;
    logic                  overflow;
    logic                  busy;
    logic                  done;
    modport master (output start, binario, con_signo, input bcd, negativo, overflow, busy, done);
    modport slave  (input start, binario, con_signo, output bcd, negativo, overflow, busy, done);
endinterface

// File: rtl/bin_bcd_secuencial.sv
// bin_bcd_secuencial: iterative double-dabble binary-to-BCD converter, one bit per clock, optional signed input
module bin_bcd_secuencial #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input logic                 clk,
    input logic                 rst,
    bin_bcd_secuencial_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BW-1:0]   work_q, work_d, adj;
    logic            sticky_q, sticky_d;
    logic            sign_q, sign_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            neg_q, neg_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic            sign_in;
    logic            last;
    // Add-3 correction: every working digit of 5 or more is bumped before the shift
    always_comb begin
        adj = work_q;
        for (int k = 0; k < DIGITS; k++)
            adj[4*k +: 4] = work_q[4*k +: 4] >= 4'd5 ? work_q[4*k +: 4] + 4'd3 : work_q[4*k +: 4];
    end
    // Next state: capture magnitude in IDLE, shift one bit per cycle in SHIFT, publish on the last shift
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sr_d     = sr_q;
        work_d   = work_q;
        sticky_d = sticky_q;
        sign_d   = sign_q;
        bcd_d    = bcd_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        sign_in  = bus.con_signo & bus.binario[WIDTH-1];
        last     = count_q == CW'(WIDTH - 1);
        if (state_q == IDLE) begin
            if (bus.start) begin
                sr_d     = sign_in ? ~bus.binario + WIDTH'(1) : bus.binario;
                work_d   = '0;
                sticky_d = 1'b0;
                count_d  = '0;
                sign_d   = sign_in;
                state_d  = SHIFT;
            end
        end else begin
            {work_d, sr_d} = {adj, sr_q} << 1;
            sticky_d       = sticky_q | adj[BW-1];
            count_d        = count_q + CW'(1);
            if (last) begin
                bcd_d   = work_d;
                neg_d   = sign_q;
                ovf_d   = sticky_d;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end
    // State register; reset aborts any conversion in flight and clears all outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            sr_q     <= '0;
            work_q   <= '0;
            sticky_q <= 1'b0;
            sign_q   <= 1'b0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sr_q     <= sr_d;
            work_q   <= work_d;
            sticky_q <= sticky_d;
            sign_q   <= sign_d;
            bcd_q    <= bcd_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end
    assign bus.bcd      = bcd_q;
    assign bus.negativo = neg_q;
    assign bus.overflow = ovf_q;
    assign bus.done     = done_q;
    assign bus.busy     = state_q == SHIFT;
endmodule

// File: tb/tb_bin_bcd_secuencial.sv
// tb_bin_bcd_secuencial: directed bench for 4-digit and 3-digit converters against an arithmetic model
module tb_bin_bcd_secuencial;
    localparam int W = 12;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         con_signo = 1'b0;
    logic [W-1:0] binario = '0;
    int           checks = 0;
    int           errors = 0;
    always #5 clk = ~clk;
    bin_bcd_secuencial_if #(.WIDTH(W), .DIGITS(4)) b4 ();
    bin_bcd_secuencial_if #(.WIDTH(W), .DIGITS(3)) b3 ();
    assign b4.start     = start;
    assign b4.binario   = binario;
    assign b4.con_signo = con_signo;
    assign b3.start     = start;
    assign b3.binario   = binario;
    assign b3.con_signo = con_signo;
    bin_bcd_secuencial #(.WIDTH(W), .DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
    bin_bcd_secuencial #(.WIDTH(W), .DIGITS(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

    bit          m_pend = 0;
    int          m_cnt = 0;
    int          m_mag = 0;
    bit          m_sign = 0;
    logic [15:0] m_bcd4 = '0;
    logic [11:0] m_bcd3 = '0;
    bit          m_neg = 0;
    bit          m_ov4 = 0;
    bit          m_ov3 = 0;
    bit          m_done = 0;

    function automatic logic [15:0] to_bcd(input int v, input int d);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p *= 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a conversion accepted in idle completes exactly W edges later with decimal digits of the magnitude
    always @(posedge clk) begin
        logic [15:0] t;
        if (rst) begin
            m_pend = 0; m_bcd4 = '0; m_bcd3 = '0; m_neg = 0; m_ov4 = 0; m_ov3 = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_pend) begin
                m_cnt++;
                if (m_cnt == W) begin
                    m_pend = 0;
                    m_done = 1;
                    m_bcd4 = to_bcd(m_mag, 4);
                    t      = to_bcd(m_mag, 3);
                    m_bcd3 = t[11:0];
                    m_ov4  = m_mag >= 10000;
                    m_ov3  = m_mag >= 1000;
                    m_neg  = m_sign;
                end
            end else if (start) begin
                m_pend = 1;
                m_cnt  = 0;
                m_sign = con_signo && binario[W-1];
                m_mag  = m_sign ? (1 << W) - int'(binario) : int'(binario);
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        chk("d4 done", b4.done, m_done);
        chk("d4 busy", b4.busy, m_pend);
        chk("d4 bcd", b4.bcd, m_bcd4);
        chk("d4 negativo", b4.negativo, m_neg);
        chk("d4 overflow", b4.overflow, m_ov4);
        chk("d3 done", b3.done, m_done);
        chk("d3 busy", b3.busy, m_pend);
        chk("d3 bcd", b3.bcd, m_bcd3);
        chk("d3 negativo", b3.negativo, m_neg);
        chk("d3 overflow", b3.overflow, m_ov3);
        chk("done&busy", b4.done & b4.busy, 0);
    end

    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = b4.busy ? 1 : 0;
        while (!b4.done && n < 40) begin
            @(negedge clk);
            n++;
            if (b4.busy) nb++;
        end
    endtask

    task automatic conv(input string name, input logic [W-1:0] v, input bit s, input logic [15:0] e4,
                        input logic [11:0] e3, input bit en, input bit eo3);
        int n, nb;
        binario = v; con_signo = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, nb);
        chk({name, " latency"}, n, 12);
        chk({name, " busy cycles"}, nb, 12);
        chk({name, " bcd4"}, b4.bcd, e4);
        chk({name, " bcd3"}, b3.bcd, e3);
        chk({name, " negativo"}, b4.negativo, en);
        chk({name, " ovf4"}, b4.overflow, 0);
        chk({name, " ovf3"}, b3.overflow, eo3);
        @(negedge clk);
    endtask

    initial begin
        int n, nb, nd;
        logic [15:0] cap;
        repeat (3) @(negedge clk);
        chk("reset bcd", b4.bcd, 0);
        chk("reset busy", b4.busy, 0);
        chk("reset done", b4.done, 0);
        chk("reset ovf", b4.overflow, 0);
        rst = 1'b0;
        @(negedge clk);
        conv("4095", 12'd4095, 0, 16'h4095, 12'h095, 0, 1);
        conv("999", 12'd999, 0, 16'h0999, 12'h999, 0, 0);
        conv("1000", 12'd1000, 0, 16'h1000, 12'h000, 0, 1);
        conv("s FFF", 12'hFFF, 1, 16'h0001, 12'h001, 1, 0);
        conv("s 800", 12'h800, 1, 16'h2048, 12'h048, 1, 1);
        conv("s 7FF", 12'h7FF, 1, 16'h2047, 12'h047, 0, 1);
        conv("u FFF", 12'hFFF, 0, 16'h4095, 12'h095, 0, 1);
        binario = 12'd0; con_signo = 1'b0; start = 1'b1;
        @(negedge clk);
        binario = 12'd1;
        wait_done(n, nb);
        chk("b2b first latency", n, 12);
        chk("b2b first bcd", b4.bcd, 16'h0000);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!b4.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b spacing", n, 13);
        chk("b2b second bcd", b4.bcd, 16'h0001);
        @(negedge clk);
        binario = 12'd321; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        binario = 12'd555; con_signo = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        cap = '0;
        repeat (30) begin
            @(negedge clk);
            if (b4.done) begin
                nd++;
                cap = b4.bcd;
            end
        end
        chk("ignored start dones", nd, 1);
        chk("ignored start bcd", cap, 16'h0321);
        con_signo = 1'b0;
        binario = 12'd1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("abort bcd", b4.bcd, 0);
        chk("abort busy", b4.busy, 0);
        chk("abort done", b4.done, 0);
        chk("abort negativo", b4.negativo, 0);
        chk("abort ovf3", b3.overflow, 0);
        rst = 1'b0; start = 1'b0;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (b4.done) nd++;
        end
        chk("abort no done", nd, 0);
        conv("1234", 12'd1234, 0, 16'h1234, 12'h234, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
